// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT magnitude ping-pong buffer: ownership states
// and the {bank, ch, bin} address composition used by both RAM ports.
package fft_buf_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        READY = 1'b1
    } buf_state_e;

    // Concatenates {bank, ch, bin}; callers cast the result down to their address width.
    function automatic logic [31:0] buf_addr(
        input logic        bank,
        input logic [15:0] ch,
        input logic [15:0] bin,
        input int          ch_aw,
        input int          bin_aw
    );
        return (32'(bank) << (ch_aw + bin_aw)) | (32'(ch) << bin_aw) | 32'(bin);
    endfunction

endpackage

// File: rtl/fft_mag_sdp_ram.sv
// Simple dual-port RAM (one write port, one read port) with a registered read
// output; the output register clears on reset, the array does not.
module fft_mag_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_mag_pingpong.sv
// Ping-pong frame buffer for FFT magnitude bins: the writer fills one bank while
// the reader consumes the other, with per-channel peak tracking per frame.
module fft_mag_pingpong
    import fft_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BIN_AW = 6,
    parameter int CH_AW  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [CH_AW-1:0]  wr_ch,
    input  logic [BIN_AW-1:0] wr_bin,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [CH_AW-1:0]  rd_ch,
    input  logic [BIN_AW-1:0] rd_bin,
    input  logic              rd_release,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] peak_val,
    output logic [BIN_AW-1:0] peak_bin,
    output logic              frame_ready,
    output logic              frame_drop,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int N_CH = 2**CH_AW;
    localparam int AW   = 1 + CH_AW + BIN_AW;

    localparam logic [0:0] ST_EMPTY = EMPTY;
    localparam logic [0:0] ST_READY = READY;

    logic [0:0]        state;
    logic              wb;
    logic              cmpl;
    logic              do_swap;
    logic              do_drop;
    logic [AW-1:0]     wr_addr;

    logic [DATA_W-1:0] run_peak [N_CH];
    logic [BIN_AW-1:0] run_bin  [N_CH];
    logic [DATA_W-1:0] nxt_peak [N_CH];
    logic [BIN_AW-1:0] nxt_bin  [N_CH];
    logic [DATA_W-1:0] rd_peak  [N_CH];
    logic [BIN_AW-1:0] rd_pbin  [N_CH];

    logic              vld_p0;
    logic [AW-1:0]     rd_addr_p0;
    logic [DATA_W-1:0] pk_val_p0;
    logic [BIN_AW-1:0] pk_bin_p0;

    assign cmpl    = wr_valid && (wr_ch == {CH_AW{1'b1}}) && (wr_bin == {BIN_AW{1'b1}});
    assign do_swap = cmpl && ((state == ST_EMPTY) || rd_release);
    assign do_drop = cmpl && (state == ST_READY) && !rd_release;
    assign wr_addr = AW'(buf_addr(wb, 16'(wr_ch), 16'(wr_bin), CH_AW, BIN_AW));

    assign frame_ready = (state == ST_READY);

    // Running peak including the current write; strict compare keeps the first bin on ties.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            nxt_peak[c] = run_peak[c];
            nxt_bin[c]  = run_bin[c];
            if (wr_valid && (wr_ch == CH_AW'(c)) && (wr_data > run_peak[c])) begin
                nxt_peak[c] = wr_data;
                nxt_bin[c]  = wr_bin;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            wb         <= 1'b0;
            frame_cnt  <= '0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= do_drop;
            if (do_swap) begin
                wb        <= ~wb;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (cmpl) begin
                state <= ST_READY;
            end else if (rd_release && (state == ST_READY)) begin
                state <= ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                run_peak[c] <= '0;
                run_bin[c]  <= '0;
                rd_peak[c]  <= '0;
                rd_pbin[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                run_peak[c] <= cmpl ? '0 : nxt_peak[c];
                run_bin[c]  <= cmpl ? '0 : nxt_bin[c];
                if (do_swap) begin
                    rd_peak[c] <= nxt_peak[c];
                    rd_pbin[c] <= nxt_bin[c];
                end
            end
        end
    end

    // ---- p0: capture read address and peak against the pre-swap read bank ----
    always_ff @(posedge clk) begin
        rd_addr_p0 <= AW'(buf_addr(~wb, 16'(rd_ch), 16'(rd_bin), CH_AW, BIN_AW));
        pk_val_p0  <= rd_peak[rd_ch];
        pk_bin_p0  <= rd_pbin[rd_ch];
    end

    // ---- p1: RAM output register and aligned peak outputs ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            rd_valid <= 1'b0;
            peak_val <= '0;
            peak_bin <= '0;
        end else begin
            vld_p0   <= rd_en;
            rd_valid <= vld_p0;
            if (vld_p0) begin
                peak_val <= pk_val_p0;
                peak_bin <= pk_bin_p0;
            end
        end
    end

    fft_mag_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_valid),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (vld_p0),
        .raddr (rd_addr_p0),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fft_mag_pingpong.sv
// Directed bench for fft_mag_pingpong: frame swap/drop/release, peaks, reset, streaming reads.
module tb_fft_mag_pingpong;

    localparam int DATA_W = 32;
    localparam int BIN_AW = 6;
    localparam int CH_AW  = 2;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_valid;
    logic [CH_AW-1:0]  wr_ch;
    logic [BIN_AW-1:0] wr_bin;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [CH_AW-1:0]  rd_ch;
    logic [BIN_AW-1:0] rd_bin;
    logic              rd_release;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] peak_val;
    logic [BIN_AW-1:0] peak_bin;
    logic              frame_ready;
    logic              frame_drop;
    logic [CNT_W-1:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_mag_pingpong #(
        .DATA_W (DATA_W),
        .BIN_AW (BIN_AW),
        .CH_AW  (CH_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ch       (wr_ch),
        .wr_bin      (wr_bin),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_bin      (rd_bin),
        .rd_release  (rd_release),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .peak_val    (peak_val),
        .peak_bin    (peak_bin),
        .frame_ready (frame_ready),
        .frame_drop  (frame_drop),
        .frame_cnt   (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ch*1000+bin+off, mode 1: ch0 has 7 at bins 3 and 9, mode 2: ch*10+bin
    task automatic write_frame(input int mode, input int off, input bit rel);
        for (int ch = 0; ch < 4; ch++) begin
            for (int bin = 0; bin < 64; bin++) begin
                wr_valid = 1'b1;
                wr_ch    = CH_AW'(ch);
                wr_bin   = BIN_AW'(bin);
                if (mode == 0)      wr_data = DATA_W'(ch * 1000 + bin + off);
                else if (mode == 1) wr_data = (ch == 0 && (bin == 3 || bin == 9)) ? 32'd7 : 32'd0;
                else                wr_data = DATA_W'(ch * 10 + bin);
                rd_release = rel && (ch == 3) && (bin == 63);
                tick();
            end
        end
        wr_valid   = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic read_one(input string tag, input int ch, input int bin,
                            input int exp_d, input int exp_pv, input int exp_pb);
        rd_en  = 1'b1;
        rd_ch  = CH_AW'(ch);
        rd_bin = BIN_AW'(bin);
        tick();
        rd_en = 1'b0;
        tick();
        check({tag, "_valid"}, 32'(rd_valid), 1);
        check({tag, "_data"}, rd_data, exp_d);
        check({tag, "_peak_val"}, peak_val, exp_pv);
        check({tag, "_peak_bin"}, 32'(peak_bin), exp_pb);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_peak_val"}, peak_val, 0);
        check({tag, "_peak_bin"}, 32'(peak_bin), 0);
        check({tag, "_frame_ready"}, 32'(frame_ready), 0);
        check({tag, "_frame_drop"}, 32'(frame_drop), 0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    initial begin
        reset      = 1'b0;
        wr_valid   = 1'b0;
        wr_ch      = '0;
        wr_bin     = '0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_ch      = '0;
        rd_bin     = '0;
        rd_release = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;

        // Frame A into an empty buffer swaps immediately
        write_frame(0, 0, 1'b0);
        check("A_ready", 32'(frame_ready), 1);
        check("A_cnt", 32'(frame_cnt), 1);
        check("A_drop", 32'(frame_drop), 0);
        read_one("A_ch2b5", 2, 5, 2005, 2063, 63);
        read_one("A_ch3b63", 3, 63, 3063, 3063, 63);

        // Frame B while A unreleased is dropped
        write_frame(0, 100, 1'b0);
        check("B_drop_hi", 32'(frame_drop), 1);
        check("B_cnt", 32'(frame_cnt), 1);
        check("B_ready", 32'(frame_ready), 1);
        tick();
        check("B_drop_lo", 32'(frame_drop), 0);
        read_one("B_ch2b5", 2, 5, 2005, 2063, 63);

        // Frame C completes in the same cycle as the release
        write_frame(0, 500, 1'b1);
        check("C_ready", 32'(frame_ready), 1);
        check("C_cnt", 32'(frame_cnt), 2);
        check("C_drop", 32'(frame_drop), 0);
        read_one("C_ch2b5", 2, 5, 2505, 2563, 63);

        // Release alone empties; a second release in EMPTY is ignored
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check("rel_ready", 32'(frame_ready), 0);
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check("rel2_ready", 32'(frame_ready), 0);
        check("rel2_cnt", 32'(frame_cnt), 2);
        read_one("stale_ch2b5", 2, 5, 2505, 2563, 63);

        // Frame D: tie handling and all-zero channel
        write_frame(1, 0, 1'b0);
        check("D_ready", 32'(frame_ready), 1);
        check("D_cnt", 32'(frame_cnt), 3);
        read_one("D_ch0b3", 0, 3, 7, 7, 3);
        read_one("D_ch1b0", 1, 0, 0, 0, 0);
        read_one("D_ch0b9", 0, 9, 7, 7, 3);

        // Partial frame of large values, then reset mid-frame
        for (int i = 0; i < 100; i++) begin
            wr_valid = 1'b1;
            wr_ch    = CH_AW'(i / 64);
            wr_bin   = BIN_AW'(i % 64);
            wr_data  = 32'd9999;
            tick();
        end
        wr_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_all_zero("midreset");
        tick();
        reset = 1'b0;

        // Frame F after reset starts fresh in bank 0
        write_frame(2, 0, 1'b0);
        check("F_ready", 32'(frame_ready), 1);
        check("F_cnt", 32'(frame_cnt), 1);
        read_one("F_ch0b63", 0, 63, 63, 63, 63);
        read_one("F_ch3b63", 3, 63, 93, 93, 63);
        read_one("F_ch0b0", 0, 0, 0, 63, 63);

        // 64 back-to-back reads of channel 1
        for (int i = 0; i < 67; i++) begin
            rd_en  = (i < 64);
            rd_ch  = CH_AW'(1);
            rd_bin = BIN_AW'(i);
            tick();
            if (i >= 1 && i <= 64) begin
                check("stream_valid", 32'(rd_valid), 1);
                check("stream_data", rd_data, 32'(10 + i - 1));
                check("stream_peak", peak_val, 73);
            end else begin
                check("stream_idle", 32'(rd_valid), 0);
            end
        end
        rd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
